ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the send-side counterpart of the keyboard receive path (ps2interface).
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the bidirectional PS2_CLK/PS2_DATA lines through open-drain enables and checks the device acknowledge.
- While `busy`=1, game logic gates the receiver: scan codes seen then are the device's own clocking.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_sync_edge.sv | 46 ++++
 rtl/ps2_host_tx.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    ACK,
    WAIT_IDLE
  } ps2State;

  // Device clock falling edges per transfer, including the ACK edge.
  localparam int unsigned FRAME_LEN = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESEND  = 8'hFE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [9:0] makeFrame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and transfer status between game logic and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Input synchroniser (preset to 1, the idle level of a PS/2 line) with an
// optional falling-edge detector on the synchronised output.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [SYNC_STAGES:0]   shifted;

  assign shifted = {syncQ, din};
  assign dout    = syncQ[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncQ <= '1;
    end else begin
      syncQ <= shifted[SYNC_STAGES-1:0];
    end
  end

  if (EDGE_EN) begin : gEdge
    logic prevQ;

    // Remember the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        prevQ <= 1'b1;
      end else begin
        prevQ <= dout;
      end
    end

    assign fall = prevQ & ~dout;
  end else begin : gNoEdge
    assign fall = 1'b0;
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Optional macro PS2_TX_RETRY_EN: retry once (silently) after the first
// ACK error or timeout of a transfer before reporting the failure.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave txIf,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned     INH_W     = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned     TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       STOP_IDX = 4'(FRAME_LEN - 2);
  // With a one-cycle inhibit the start bit must already be driven on entry.
  localparam logic             START_NOW = (INHIBIT_CYCLES == 1);

  ps2State          stateQ, stateD;
  logic [INH_W-1:0] inhCntQ, inhCntD;
  logic [TO_W-1:0]  toCntQ, toCntD;
  logic [3:0]       bitCntQ, bitCntD;
  logic [9:0]       frameQ, frameD;
  logic             dataOeQ, dataOeD;
  logic             doneQ, doneD;
  logic             ackErrQ, ackErrD;
  logic             toErrQ, toErrD;
  logic             failAck, failTo;
`ifdef PS2_TX_RETRY_EN
  logic             retryQ, retryD;
`endif

  logic clkSync, clkFall;
  logic dataSync, dataFallUnused;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_EN    (1'b1)
  ) uClkSync (
    .clk (clk),
    .rst (rst),
    .din (ps2_clk_i),
    .dout(clkSync),
    .fall(clkFall)
  );

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_EN    (1'b0)
  ) uDataSync (
    .clk (clk),
    .rst (rst),
    .din (ps2_data_i),
    .dout(dataSync),
    .fall(dataFallUnused)
  );

  // State, counters, latched frame and registered line/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= IDLE;
      inhCntQ <= '0;
      toCntQ  <= '0;
      bitCntQ <= '0;
      frameQ  <= '0;
      dataOeQ <= 1'b0;
      doneQ   <= 1'b0;
      ackErrQ <= 1'b0;
      toErrQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      inhCntQ <= inhCntD;
      toCntQ  <= toCntD;
      bitCntQ <= bitCntD;
      frameQ  <= frameD;
      dataOeQ <= dataOeD;
      doneQ   <= doneD;
      ackErrQ <= ackErrD;
      toErrQ  <= toErrD;
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Marks that the current transfer has already used its one retry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retryQ <= 1'b0;
    end else begin
      retryQ <= retryD;
    end
  end
`endif

  // Next-state, bit sequencing, timeout and failure handling.
  always_comb begin
    stateD  = stateQ;
    inhCntD = inhCntQ;
    toCntD  = toCntQ;
    bitCntD = bitCntQ;
    frameD  = frameQ;
    dataOeD = dataOeQ;
    doneD   = 1'b0;
    ackErrD = 1'b0;
    toErrD  = 1'b0;
    failAck = 1'b0;
    failTo  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retryD  = retryQ;
`endif

    unique case (stateQ)
      IDLE: begin
        dataOeD = 1'b0;
        if (txIf.tx_valid) begin
          frameD  = makeFrame(txIf.tx_data);
          inhCntD = '0;
          dataOeD = START_NOW;
          stateD  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retryD  = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        // Device clock edges are ignored here: the host is holding the clock.
        inhCntD = inhCntQ + 1'b1;
        if (inhCntQ == INH_PRE) begin
          dataOeD = 1'b1;
        end
        if (inhCntQ == INH_LAST) begin
          bitCntD = '0;
          toCntD  = '0;
          stateD  = START;
        end
      end
      START: begin
        if (clkFall) begin
          dataOeD = ~frameQ[bitCntQ];
          bitCntD = bitCntQ + 4'd1;
          if (bitCntQ == STOP_IDX) begin
            stateD = ACK;
          end
        end
      end
      ACK: begin
        if (clkFall) begin
          if (dataSync) begin
            failAck = 1'b1;
          end else begin
            stateD = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clkSync && dataSync) begin
          doneD  = 1'b1;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase

    // Device-clock watchdog; the counter value counts cycles since the last edge.
    if (stateQ == START || stateQ == ACK || stateQ == WAIT_IDLE) begin
      toCntD = clkFall ? TO_W'(1) : toCntQ + 1'b1;
      if (!clkFall && !doneD && toCntQ == TO_LAST) begin
        failTo = 1'b1;
      end
    end

    if (failAck || failTo) begin
      dataOeD = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retryQ) begin
        retryD  = 1'b1;
        inhCntD = '0;
        dataOeD = START_NOW;
        stateD  = INHIBIT;
      end else begin
        ackErrD = failAck;
        toErrD  = failTo;
        stateD  = IDLE;
      end
`else
      ackErrD = failAck;
      toErrD  = failTo;
      stateD  = IDLE;
`endif
    end
  end

  // Clock enable follows the state so a reset releases it immediately.
  always_comb begin
    ps2_clk_oe       = (stateQ == INHIBIT);
    ps2_data_oe      = dataOeQ;
    txIf.tx_ready    = (stateQ == IDLE);
    txIf.busy        = (stateQ != IDLE);
    txIf.done        = doneQ;
    txIf.ack_err     = ackErrQ;
    txIf.timeout_err = toErrQ;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH   = 100;
  localparam int unsigned TO    = 2000;
  localparam int unsigned SYNC  = 2;
  localparam int          HALF  = 20;
  localparam int          LIMIT = 3 * TO;

  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_ACK  = 2'd1;
  localparam logic [1:0] K_TO   = 2'd2;

  localparam int DEV_ACK   = 0;
  localparam int DEV_NACK  = 1;
  localparam int DEV_STOP  = 2;
  localparam int DEV_RESET = 3;

  typedef struct packed {
    logic [1:0] kind;
    logic [9:0] frame;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2ClkOe, ps2DataOe;
  logic devClkLow  = 1'b0;
  logic devDataLow = 1'b0;
  logic clkLine, dataLine;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   inhibitSeen = 0;
  int   lastFeCyc = 0;
  logic [9:0] devFrame = '0;
  expT  expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign clkLine  = ~(ps2ClkOe | devClkLow);
  assign dataLine = ~(ps2DataOe | devDataLow);

  ps2_host_tx_if txIf ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .txIf       (txIf),
    .ps2_clk_i  (clkLine),
    .ps2_data_i (dataLine),
    .ps2_clk_oe (ps2ClkOe),
    .ps2_data_oe(ps2DataOe)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Outcome monitor: pops the scoreboard on every status pulse.
  initial begin
    expT  e;
    logic [1:0] k;
    forever begin
      @(negedge clk);
      if (rst && (txIf.done || txIf.ack_err || txIf.timeout_err)) begin
        check("one_pulse", 32'(txIf.done) + 32'(txIf.ack_err) + 32'(txIf.timeout_err), 1);
        k = txIf.done ? K_DONE : (txIf.ack_err ? K_ACK : K_TO);
        check("pulse_expected", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          check("outcome", k, e.kind);
          if (k != K_TO) check("frame_bits", devFrame, e.frame);
          else check("timeout_latency", cyc - lastFeCyc, SYNC + TO);
        end
        check("idle_after", {txIf.busy, txIf.tx_ready, ps2ClkOe, ps2DataOe}, 4'b0100);
      end
    end
  end

  // Inhibit monitor: clock hold length and start bit placement.
  initial begin
    int   inhRun = 0;
    logic prevDataOe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        inhRun = 0;
      end else if (ps2ClkOe) begin
        if (inhRun == 0) check("no_early_start", ps2DataOe, 0);
        inhRun++;
        prevDataOe = ps2DataOe;
      end else if (inhRun != 0) begin
        check("inhibit_len", inhRun, INH);
        check("start_in_final", prevDataOe, 1);
        inhibitSeen++;
        inhRun = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1);
  end

  task automatic sendByte(input logic [7:0] d, input logic [1:0] kind,
                          input logic [9:0] frame, input bit push);
    int t = 0;
    while (!txIf.tx_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", txIf.tx_ready, 1);
    txIf.tx_data  = d;
    txIf.tx_valid = 1'b1;
    @(negedge clk);
    txIf.tx_valid = 1'b0;
    txIf.tx_data  = 8'h5A;  // must not reach the line
    if (push) expQ.push_back('{kind: kind, frame: frame});
  endtask

  // Device model: waits for inhibit then start bit, clocks the frame,
  // captures line bits at rising edges and answers the ACK slot.
  task automatic device(input int mode);
    int t = 0;
    devFrame = '0;
    while (!ps2ClkOe && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    while (!(!ps2ClkOe && ps2DataOe) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", t < LIMIT, 1);
    if (t >= LIMIT) return;
    waitCycles(HALF);
    for (int i = 1; i <= 11; i++) begin
      if (mode == DEV_STOP && i > 4) return;
      devClkLow = 1'b1;
      lastFeCyc = cyc;
      if (mode == DEV_RESET && i == 5) begin
        waitCycles(SYNC + 2);
        rst = 1'b0;
        #1;
        check("rst_clk_oe", ps2ClkOe, 0);
        check("rst_data_oe", ps2DataOe, 0);
        check("rst_ready", {txIf.tx_ready, txIf.busy}, 2'b10);
        @(negedge clk);
        devClkLow = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      waitCycles(HALF);
      devClkLow = 1'b0;
      if (i <= 10) devFrame[i-1] = dataLine;
      if (i == 10 && mode != DEV_NACK) devDataLow = 1'b1;
      if (i == 11) devDataLow = 1'b0;
      waitCycles(HALF);
    end
  endtask

  task automatic waitIdle(input int limit);
    int t = 0;
    while (txIf.busy && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", txIf.busy, 0);
  endtask

  initial begin
    int expInhibits;
    txIf.tx_valid = 1'b0;
    txIf.tx_data  = 8'h00;
    waitCycles(3);
    #1;
    check("reset_ready", txIf.tx_ready, 1);
    check("reset_busy", txIf.busy, 0);
    check("reset_oe", {ps2ClkOe, ps2DataOe}, 2'b00);
    check("reset_pulses", {txIf.done, txIf.ack_err, txIf.timeout_err}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    waitCycles(2);

    // Set-LED command: 1,0,1,1,0,1,1,1 parity 1 stop 1.
    sendByte(CMD_SET_LED, K_DONE, 10'h3ED, 1'b1);
    device(DEV_ACK);
    waitIdle(LIMIT);

    // Parity corners.
    sendByte(8'h00, K_DONE, 10'h300, 1'b1);
    device(DEV_ACK);
    waitIdle(LIMIT);
    sendByte(8'h01, K_DONE, 10'h201, 1'b1);
    device(DEV_ACK);
    waitIdle(LIMIT);

    // Device answers ACK=1.
    sendByte(CMD_ECHO, K_ACK, 10'h3EE, 1'b1);
    device(DEV_NACK);
`ifdef PS2_TX_RETRY_EN
    device(DEV_NACK);
`endif
    waitIdle(LIMIT);

    // Device stops clocking after four edges.
    sendByte(CMD_ENABLE, K_TO, 10'h000, 1'b1);
    device(DEV_STOP);
`ifdef PS2_TX_RETRY_EN
    device(DEV_STOP);
`endif
    waitIdle(LIMIT);

    // Reset in the middle of a frame, then a clean frame.
    sendByte(8'hA5, K_DONE, 10'h3A5, 1'b0);
    device(DEV_RESET);
    waitCycles(5);
    sendByte(CMD_RESEND, K_DONE, 10'h2FE, 1'b1);
    device(DEV_ACK);
    waitIdle(LIMIT);

    // A second request while busy must be ignored.
    sendByte(CMD_SET_LED, K_DONE, 10'h3ED, 1'b1);
    fork
      device(DEV_ACK);
      begin
        waitCycles(200);
        txIf.tx_data  = CMD_RESET;
        txIf.tx_valid = 1'b1;
        @(negedge clk);
        txIf.tx_valid = 1'b0;
      end
    join
    waitIdle(LIMIT);
    waitCycles(4 * INH);

    check("queue_drained", expQ.size(), 0);
`ifdef PS2_TX_RETRY_EN
    expInhibits = 10;
`else
    expInhibits = 8;
`endif
    check("inhibit_count", inhibitSeen, expInhibits);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
